// File: rtl/cp0_regfile_pkg.sv
// Shared constants and types for the CP0 register file: register numbers,
// committed exception codes, Status/Cause field positions and the Cause layout.
package cp0_regfile_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned HW_INT_W   = 6;
    localparam int unsigned EXC_CODE_W = 5;

    localparam logic [REG_ADDR_W-1:0] CP0_REG_BADVADDR = 5'd8;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_COUNT    = 5'd9;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_COMPARE  = 5'd11;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_STATUS   = 5'd12;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_CAUSE    = 5'd13;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_EPC      = 5'd14;
    localparam logic [REG_ADDR_W-1:0] CP0_REG_PRID     = 5'd15;

    localparam logic [DATA_W-1:0] EXC_TYPE_NOEXC = 32'd0;
    localparam logic [DATA_W-1:0] EXC_TYPE_INT   = 32'd1;
    localparam logic [DATA_W-1:0] EXC_TYPE_ADEL  = 32'd4;
    localparam logic [DATA_W-1:0] EXC_TYPE_ADES  = 32'd5;
    localparam logic [DATA_W-1:0] EXC_TYPE_ERET  = 32'd14;

    localparam logic [EXC_CODE_W-1:0] EXCCODE_INT = 5'd0;

    localparam int unsigned       STATUS_EXL_BIT    = 1;
    localparam logic [DATA_W-1:0] STATUS_RESET      = 32'h0040_0000;
    localparam logic [DATA_W-1:0] STATUS_WMASK      = 32'h0000_FF03;
    localparam logic [DATA_W-1:0] CP0_PRID_DEFAULT  = 32'h0001_8000;

    typedef struct packed {
        logic                  bd;
        logic                  ti;
        logic [13:0]           rsvd_29_16;
        logic [7:0]            ip;
        logic                  rsvd_7;
        logic [EXC_CODE_W-1:0] exc_code;
        logic [1:0]            rsvd_1_0;
    } cause_t;

    // Interrupts report ExcCode 0; every other committed code reports itself.
    function automatic logic [EXC_CODE_W-1:0] exc_code_of(input logic [DATA_W-1:0] exc_type);
        if (exc_type == EXC_TYPE_INT) begin
            return EXCCODE_INT;
        end
        return exc_type[EXC_CODE_W-1:0];
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// CP0 Count/Compare timer: Count advances every second cycle, TI latches on a
// Count==Compare match (Compare nonzero) and is cleared by any Compare write.
module cp0_timer
    import cp0_regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              count_we,
    input  logic              compare_we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] compare,
    output logic              ti
);

    logic half_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            half_q  <= 1'b0;
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            half_q <= ~half_q;

            // A software write to Count takes precedence over the tick.
            if (count_we) begin
                count <= wdata;
            end else if (half_q) begin
                count <= count + DATA_W'(1);
            end

            if (compare_we) begin
                compare <= wdata;
            end

            // Clearing by a Compare write wins over a match on the same edge.
            if (compare_we) begin
                ti <= 1'b0;
            end else if ((count == compare) && (compare != '0)) begin
                ti <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// MIPS32 CP0 register file: commits MEM-stage exceptions/ERET, serves MTC0/MFC0.
// Build option CP0_TIMER_INT_EN: timer interrupt is ORed into Cause.IP[7] (HW5).
module cp0_regfile
    import cp0_regfile_pkg::*;
#(
    parameter logic [31:0] PRID = CP0_PRID_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [5:0]  int_i,
    input  logic [31:0] except_type_i,
    input  logic [31:0] pcM,
    input  logic        is_in_delayslotM,
    input  logic [31:0] badvaddrM,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);

    logic [DATA_W-1:0]     status_q;
    logic [DATA_W-1:0]     epc_q;
    logic [DATA_W-1:0]     badvaddr_q;
    logic                  bd_q;
    logic [EXC_CODE_W-1:0] exc_code_q;
    logic [1:0]            ip_sw_q;
    logic [HW_INT_W-1:0]   ip_hw_q;
    logic                  ti;

    logic   exc_commit_c;
    logic   eret_c;
    logic   addr_err_c;
    logic   mtc0_c;
    logic   count_we_c;
    logic   compare_we_c;
    logic   ip7_c;
    cause_t cause_c;

    // An exception or ERET in MEM squashes any MTC0 in the same cycle.
    assign exc_commit_c = (except_type_i != EXC_TYPE_NOEXC) && (except_type_i != EXC_TYPE_ERET);
    assign eret_c       = (except_type_i == EXC_TYPE_ERET);
    assign addr_err_c   = (except_type_i == EXC_TYPE_ADEL) || (except_type_i == EXC_TYPE_ADES);
    assign mtc0_c       = we_i && !exc_commit_c && !eret_c;
    assign count_we_c   = mtc0_c && (waddr_i == CP0_REG_COUNT);
    assign compare_we_c = mtc0_c && (waddr_i == CP0_REG_COMPARE);

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (count_we_c),
        .compare_we (compare_we_c),
        .wdata      (wdata_i),
        .count      (count_o),
        .compare    (compare_o),
        .ti         (ti)
    );

    // Hardware interrupt lines are sampled every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ip_hw_q <= '0;
        end else begin
            ip_hw_q <= int_i;
        end
    end

    // Exception/ERET commit and MTC0 writes to Status, Cause, EPC, BadVAddr.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RESET;
            epc_q      <= '0;
            badvaddr_q <= '0;
            bd_q       <= 1'b0;
            exc_code_q <= '0;
            ip_sw_q    <= '0;
        end else if (exc_commit_c) begin
            // Nested exceptions keep the original return point.
            if (!status_q[STATUS_EXL_BIT]) begin
                epc_q <= is_in_delayslotM ? (pcM - DATA_W'(4)) : pcM;
                bd_q  <= is_in_delayslotM;
            end
            status_q[STATUS_EXL_BIT] <= 1'b1;
            exc_code_q               <= exc_code_of(except_type_i);
            if (addr_err_c) begin
                badvaddr_q <= badvaddrM;
            end
        end else if (eret_c) begin
            status_q[STATUS_EXL_BIT] <= 1'b0;
        end else if (mtc0_c) begin
            case (waddr_i)
                CP0_REG_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                CP0_REG_CAUSE:  ip_sw_q  <= wdata_i[9:8];
                CP0_REG_EPC:    epc_q    <= wdata_i;
                default:        ;
            endcase
        end
    end

`ifdef CP0_TIMER_INT_EN
    assign ip7_c = ip_hw_q[5] | ti;
`else
    assign ip7_c = ip_hw_q[5];
`endif

    always_comb begin
        cause_c          = '0;
        cause_c.bd       = bd_q;
        cause_c.ti       = ti;
        cause_c.ip       = {ip7_c, ip_hw_q[4:0], ip_sw_q};
        cause_c.exc_code = exc_code_q;
    end

    // MFC0 read port; unmapped registers read as zero.
    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            CP0_REG_BADVADDR: rdata_o = badvaddr_q;
            CP0_REG_COUNT:    rdata_o = count_o;
            CP0_REG_COMPARE:  rdata_o = compare_o;
            CP0_REG_STATUS:   rdata_o = status_q;
            CP0_REG_CAUSE:    rdata_o = cause_c;
            CP0_REG_EPC:      rdata_o = epc_q;
            CP0_REG_PRID:     rdata_o = PRID;
            default:          rdata_o = '0;
        endcase
    end

    assign status_o    = status_q;
    assign cause_o     = cause_c;
    assign epc_o       = epc_q;
    assign badvaddr_o  = badvaddr_q;
    assign timer_int_o = ti;

endmodule

// File: tb/tb_cp0_regfile.sv
// Self-checking bench for cp0_regfile: directed vector table, timer/reset
// sequences, then randomized traffic against a behavioural model.
module tb_cp0_regfile;

    localparam logic [31:0] PRID_V = 32'h0001_8000;
`ifdef CP0_TIMER_INT_EN
    localparam bit TIMER_IRQ = 1'b1;
`else
    localparam bit TIMER_IRQ = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        we_i;
    logic [4:0]  waddr_i;
    logic [31:0] wdata_i;
    logic [4:0]  raddr_i;
    logic [31:0] rdata_o;
    logic [5:0]  int_i;
    logic [31:0] except_type_i;
    logic [31:0] pcM;
    logic        is_in_delayslotM;
    logic [31:0] badvaddrM;
    logic [31:0] status_o;
    logic [31:0] cause_o;
    logic [31:0] epc_o;
    logic [31:0] badvaddr_o;
    logic [31:0] count_o;
    logic [31:0] compare_o;
    logic        timer_int_o;

    int n_tests = 0;
    int n_fail  = 0;

    cp0_regfile #(.PRID(PRID_V)) dut (
        .clk              (clk),
        .rst              (rst),
        .we_i             (we_i),
        .waddr_i          (waddr_i),
        .wdata_i          (wdata_i),
        .raddr_i          (raddr_i),
        .rdata_o          (rdata_o),
        .int_i            (int_i),
        .except_type_i    (except_type_i),
        .pcM              (pcM),
        .is_in_delayslotM (is_in_delayslotM),
        .badvaddrM        (badvaddrM),
        .status_o         (status_o),
        .cause_o          (cause_o),
        .epc_o            (epc_o),
        .badvaddr_o       (badvaddr_o),
        .count_o          (count_o),
        .compare_o        (compare_o),
        .timer_int_o      (timer_int_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        we_i = 1'b0; waddr_i = '0; wdata_i = '0; raddr_i = '0; int_i = '0;
        except_type_i = '0; pcM = '0; is_in_delayslotM = 1'b0; badvaddrM = '0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we_i = 1'b1; waddr_i = a; wdata_i = d;
        @(posedge clk); #1;
        we_i = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [31:0] exc;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] badv;
        logic [5:0]  intv;
        logic [4:0]  rreg;
        logic [31:0] exp;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [31:0] exc, input logic [31:0] pc, input logic ds,
                                input logic [31:0] badv, input logic [5:0] intv,
                                input logic [4:0] rreg, input logic [31:0] exp);
        vec_t v;
        v.we = we; v.waddr = waddr; v.wdata = wdata; v.exc = exc; v.pc = pc; v.ds = ds;
        v.badv = badv; v.intv = intv; v.rreg = rreg; v.exp = exp;
        return v;
    endfunction

    task automatic apply_vec(input int idx, input vec_t v);
        @(negedge clk);
        we_i = v.we; waddr_i = v.waddr; wdata_i = v.wdata; except_type_i = v.exc;
        pcM = v.pc; is_in_delayslotM = v.ds; badvaddrM = v.badv; int_i = v.intv;
        @(posedge clk); #1;
        we_i = 1'b0; except_type_i = '0;
        raddr_i = v.rreg;
        #1;
        check($sformatf("vec%0d_reg%0d", idx, v.rreg), rdata_o, v.exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_status, m_epc, m_badv, m_count, m_compare;
    logic        m_bd, m_ti, m_half;
    logic [4:0]  m_exc;
    logic [1:0]  m_ipsw;
    logic [5:0]  m_int;

    task automatic model_reset();
        m_status = 32'h0040_0000; m_epc = '0; m_badv = '0; m_count = '0; m_compare = '0;
        m_bd = 1'b0; m_ti = 1'b0; m_half = 1'b0; m_exc = '0; m_ipsw = '0; m_int = '0;
    endtask

    function automatic logic [31:0] m_cause();
        logic hw5;
        hw5 = m_int[5] | (TIMER_IRQ & m_ti);
        return {m_bd, m_ti, 14'd0, hw5, m_int[4:0], m_ipsw, 1'b0, m_exc, 2'b00};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_badv;
            5'd9:    return m_count;
            5'd11:   return m_compare;
            5'd12:   return m_status;
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'd0;
        endcase
    endfunction

    // Advances the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit          is_exc, is_eret, mtc;
        logic [31:0] n_count;
        logic        n_ti;
        is_exc  = (except_type_i != 32'd0) && (except_type_i != 32'd14);
        is_eret = (except_type_i == 32'd14);
        mtc     = we_i && !is_exc && !is_eret;

        n_ti = m_ti;
        if (mtc && waddr_i == 5'd11) n_ti = 1'b0;
        else if (m_count == m_compare && m_compare != 32'd0) n_ti = 1'b1;
        if (mtc && waddr_i == 5'd9) n_count = wdata_i;
        else n_count = m_half ? m_count + 32'd1 : m_count;

        if (is_exc) begin
            if (m_status[1] == 1'b0) begin
                m_epc = is_in_delayslotM ? pcM - 32'd4 : pcM;
                m_bd  = is_in_delayslotM;
            end
            m_status[1] = 1'b1;
            m_exc = (except_type_i == 32'd1) ? 5'd0 : except_type_i[4:0];
            if (except_type_i == 32'd4 || except_type_i == 32'd5) m_badv = badvaddrM;
        end else if (is_eret) begin
            m_status[1] = 1'b0;
        end else if (mtc) begin
            case (waddr_i)
                5'd11: m_compare = wdata_i;
                5'd12: begin
                    m_status[15:8] = wdata_i[15:8];
                    m_status[1:0]  = wdata_i[1:0];
                end
                5'd13: m_ipsw = wdata_i[9:8];
                5'd14: m_epc = wdata_i;
                default: ;
            endcase
        end
        m_count = n_count;
        m_ti    = n_ti;
        m_half  = ~m_half;
        m_int   = int_i;
    endtask

    task automatic random_phase(input int ncycles);
        logic [4:0] regs[8];
        logic [31:0] exc_pick[9];
        regs     = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        exc_pick = '{32'd1, 32'd4, 32'd5, 32'd8, 32'd9, 32'd10, 32'd12, 32'd14, 32'd14};
        for (int c = 0; c < ncycles; c++) begin
            we_i    = ($urandom_range(0, 3) == 0);
            waddr_i = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31)) : regs[$urandom_range(0, 6)];
            wdata_i = $urandom;
            if ((waddr_i == 5'd9 || waddr_i == 5'd11) && $urandom_range(0, 1) == 1)
                wdata_i = 32'($urandom_range(0, 12));
            except_type_i    = ($urandom_range(0, 15) < 10) ? 32'd0 : exc_pick[$urandom_range(0, 8)];
            pcM              = $urandom & 32'hFFFF_FFFC;
            is_in_delayslotM = 1'($urandom_range(0, 1));
            badvaddrM        = $urandom;
            int_i            = 6'($urandom_range(0, 63));
            raddr_i          = 5'($urandom_range(0, 31));
            #1;
            check($sformatf("rnd%0d_status", c), status_o, m_status);
            check($sformatf("rnd%0d_cause", c), cause_o, m_cause());
            check($sformatf("rnd%0d_epc", c), epc_o, m_epc);
            check($sformatf("rnd%0d_badvaddr", c), badvaddr_o, m_badv);
            check($sformatf("rnd%0d_count", c), count_o, m_count);
            check($sformatf("rnd%0d_compare", c), compare_o, m_compare);
            check($sformatf("rnd%0d_ti", c), 32'(timer_int_o), 32'(m_ti));
            check($sformatf("rnd%0d_rdata%0d", c, raddr_i), rdata_o, m_read(raddr_i));
            model_step();
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        bit found;

        // Expected values follow the architectural rules for each step.
        vecs[0]  = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     12, 32'h0040_0000);
        vecs[1]  = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     15, PRID_V);
        vecs[2]  = mk(0, 0,  0,            12, 32'hbfc0_1004, 1, 0,           6'b0,     14, 32'hbfc0_1000);
        vecs[3]  = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     13, 32'h8000_0030);
        vecs[4]  = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     12, 32'h0040_0002);
        vecs[5]  = mk(0, 0,  0,            4,  32'h0000_0100, 0, 32'h0000_0003, 6'b0,   14, 32'hbfc0_1000);
        vecs[6]  = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     8,  32'h0000_0003);
        vecs[7]  = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     13, 32'h8000_0010);
        vecs[8]  = mk(0, 0,  0,            14, 0,            0, 0,            6'b0,     12, 32'h0040_0000);
        vecs[9]  = mk(1, 12, 32'hFFFF_FFFF, 8, 32'h0000_2000, 0, 0,           6'b0,     12, 32'h0040_0002);
        vecs[10] = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     14, 32'h0000_2000);
        vecs[11] = mk(1, 12, 32'hFFFF_FFFF, 0, 0,            0, 0,            6'b0,     12, 32'h0040_FF03);
        vecs[12] = mk(1, 13, 32'hFFFF_FFFF, 0, 0,            0, 0,            6'b0,     13, 32'h0000_0320);
        vecs[13] = mk(1, 14, 32'h1234_5678, 0, 0,            0, 0,            6'b0,     14, 32'h1234_5678);
        vecs[14] = mk(0, 0,  0,            0,  0,            0, 0,            6'b000100, 13, 32'h0000_1320);
        vecs[15] = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     13, 32'h0000_0320);
        vecs[16] = mk(1, 14, 32'hDEAD_BEEF, 14, 0,           0, 0,            6'b0,     14, 32'h1234_5678);
        vecs[17] = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     12, 32'h0040_FF01);
        vecs[18] = mk(1, 15, 32'h0,        0,  0,            0, 0,            6'b0,     15, PRID_V);
        vecs[19] = mk(1, 8,  32'h5555_5555, 0, 0,            0, 0,            6'b0,     8,  32'h0000_0003);
        vecs[20] = mk(0, 0,  0,            0,  0,            0, 0,            6'b0,     3,  32'h0);
        vecs[21] = mk(0, 0,  0,            1,  32'h0000_0400, 0, 0,           6'b0,     13, 32'h0000_0300);
        vecs[22] = mk(0, 0,  0,            5,  32'h0000_0500, 0, 32'hABCD_0001, 6'b0,   8,  32'hABCD_0001);

        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        raddr_i = 5'd12;
        #1;
        check("rst_status", status_o, 32'h0040_0000);
        check("rst_cause", cause_o, 32'h0);
        check("rst_epc", epc_o, 32'h0);
        check("rst_badvaddr", badvaddr_o, 32'h0);
        check("rst_count", count_o, 32'h0);
        check("rst_compare", compare_o, 32'h0);
        check("rst_ti", 32'(timer_int_o), 32'h0);
        check("rst_rd_status", rdata_o, 32'h0040_0000);

        // Count advances once per two cycles.
        repeat (10) @(posedge clk);
        #1;
        raddr_i = 5'd9;
        #1;
        check("count_10cyc", count_o, 32'd5);
        check("count_rd", rdata_o, 32'd5);

        for (int i = 0; i < NVEC; i++) apply_vec(i, vecs[i]);

        // Timer match: TI rises the edge after Count reaches Compare.
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd8);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (count_o == 32'd8) found = 1'b1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("timer_reach8", count_o, 32'd8);
        check("ti_at_match", 32'(timer_int_o), 32'd0);
        @(posedge clk); #1;
        check("ti_after_match", 32'(timer_int_o), 32'd1);
        check("cause_ti", 32'(cause_o[30]), 32'd1);
        check("cause_ip7", 32'(cause_o[15]), 32'(TIMER_IRQ));
        mtc0(5'd11, 32'd20);
        check("ti_cleared", 32'(timer_int_o), 32'd0);
        check("cause_ti_cleared", 32'(cause_o[30]), 32'd0);

        // Compare==0 never raises TI even while Count equals it.
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("ti_compare0", 32'(timer_int_o), 32'd0);

        // Count wraps silently.
        mtc0(5'd9, 32'hFFFF_FFFF);
        check("count_max", count_o, 32'hFFFF_FFFF);
        for (int i = 0; i < 3 && count_o != 32'd0; i++) begin
            @(posedge clk); #1;
        end
        check("count_wrap", count_o, 32'd0);

        // Reset beats a same-cycle exception and MTC0.
        @(negedge clk);
        rst = 1'b1; except_type_i = 32'd12; pcM = 32'h0000_0800;
        we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("midrst_status", status_o, 32'h0040_0000);
        check("midrst_epc", epc_o, 32'h0);
        check("midrst_cause", cause_o, 32'h0);
        clear_inputs();

        @(negedge clk);
        rst = 1'b0;
        model_reset();
        random_phase(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
